// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the loadable instruction memory and its byte loader.
package inst_mem_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam int unsigned BYTE_IDX_W   = 2;

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_WRITE,
        S_DONE
    } ld_state_e;

    function automatic int unsigned word_idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ld_word_assembler.sv
// Packs four little-endian loader bytes into a 32-bit word; word_ready_o marks the 4th byte.
module ld_word_assembler
    import inst_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    logic [BYTE_IDX_W-1:0] idx_q;
    logic [31:0]           word_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            idx_q <= '0;
        end else if (byte_vld_i) begin
            idx_q <= idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (byte_vld_i) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_i;
        end
    end

    assign word_o       = word_q;
    assign word_ready_o = byte_vld_i && (idx_q == 2'd3);

endmodule

// File: rtl/inst_mem_loadable.sv
// Word-addressed instruction memory with 1-cycle fetch port and runtime byte-stream loader.
// Optional per-word even parity with fault reporting is enabled by defining INST_MEM_PARITY_EN.
module inst_mem_loadable
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] NOP_INST    = NOP_INST_DEF
) (
    input  logic                           clk_50,
    input  logic                           rst,
    input  logic                           fetch_req,
    input  logic [ADDR_W-1:0]              fetch_addr,
    output logic                           fetch_ready,
    output logic                           fetch_valid,
    output logic [31:0]                    fetch_inst,
    output logic                           fetch_fault,
    input  logic                           ld_start,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_base,
    input  logic [$clog2(DEPTH_WORDS):0]   ld_count,
    input  logic                           ld_valid,
    input  logic [7:0]                     ld_byte,
    output logic                           ld_ready,
    output logic                           ld_done,
    output logic                           busy
`ifdef INST_MEM_PARITY_EN
    ,
    input  logic                           parity_inject
`endif
);

    localparam int unsigned IW = word_idx_w(DEPTH_WORDS);
`ifdef INST_MEM_PARITY_EN
    localparam int unsigned MEM_W = 33;
`else
    localparam int unsigned MEM_W = 32;
`endif
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [IW:0]     ONE_W      = (IW+1)'(1);

    ld_state_e         state_q, state_d;
    logic [IW-1:0]     base_q;
    logic [IW:0]       count_q;
    logic [IW:0]       wcnt_q;
    logic              ld_done_q, ld_done_d;
    logic              last_word;
    logic [IW-1:0]     waddr;
    logic [31:0]       asm_word;
    logic              word_ready;
    logic [MEM_W-1:0]  wdata;
    logic [MEM_W-1:0]  mem_q [DEPTH_WORDS];

    logic              fetch_acc;
    logic [IW-1:0]     ridx;
    logic [MEM_W-1:0]  rd_entry;
    logic              par_err;
    logic              fault;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic [31:0]       fetch_inst_q, fetch_inst_d;

    ld_word_assembler u_asm (
        .clk_i        (clk_50),
        .rst_i        (rst),
        .clr_i        (state_q == S_RUN),
        .byte_vld_i   (ld_valid && ld_ready),
        .byte_i       (ld_byte),
        .word_o       (asm_word),
        .word_ready_o (word_ready)
    );

    assign last_word = ((wcnt_q + ONE_W) == count_q);
    assign waddr     = base_q + wcnt_q[IW-1:0];

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (ld_start && (ld_count != '0)) state_d = S_LOAD;
            S_LOAD:  if (word_ready) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        fetch_ready = (state_q == S_RUN);
        ld_ready    = (state_q == S_LOAD);
        busy        = (state_q != S_RUN);
    end

    // A zero-length load completes from RUN without ever leaving it.
    assign ld_done_d = ((state_q == S_WRITE) && last_word)
                    || ((state_q == S_RUN) && ld_start && (ld_count == '0));

    always_ff @(posedge clk_50) begin
        if (rst) begin
            wcnt_q    <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= ld_done_d;
            if ((state_q == S_RUN) && ld_start && (ld_count != '0)) begin
                wcnt_q <= '0;
            end else if (state_q == S_WRITE) begin
                wcnt_q <= wcnt_q + ONE_W;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if ((state_q == S_RUN) && ld_start && (ld_count != '0)) begin
            base_q  <= ld_base;
            count_q <= ld_count;
        end
    end

`ifdef INST_MEM_PARITY_EN
    assign wdata   = {(^asm_word) ^ parity_inject, asm_word};
    assign par_err = ^rd_entry;
`else
    assign wdata   = asm_word;
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk_50) begin
        if (state_q == S_WRITE) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign fetch_acc = fetch_req && fetch_ready;
    assign ridx      = fetch_addr[IW+1:2];
    assign rd_entry  = mem_q[ridx];
    assign fault     = (fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_addr} >= ADDR_LIMIT) || par_err;

    always_comb begin
        fetch_valid_d = fetch_acc;
        fetch_fault_d = fetch_acc && fault;
        fetch_inst_d  = fetch_inst_q;
        if (fetch_acc) begin
            fetch_inst_d = fault ? NOP_INST : rd_entry[31:0];
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_inst_q  <= NOP_INST;
        end else begin
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fetch_inst_q  <= fetch_inst_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fetch_inst  = fetch_inst_q;
    assign ld_done     = ld_done_q;

endmodule
